// File: rtl/mic_frame_packer.sv
// Buffers 32-bit mic-array samples in a FIFO and emits raw Ethernet frames
// (L2 header, sequence number, samples) on an Avalon-ST source. Optional macro: MIC_FRAME_TIMESTAMP_EN.
module mic_frame_packer #(
  parameter int          SAMPLES_PER_FRAME = 64,
  parameter int          FIFO_DEPTH        = 256,
  parameter logic [47:0] DST_MAC           = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC           = 48'h0001_0203_0405,
  parameter logic [15:0] ETHERTYPE         = 16'h88B5
) (
  input  logic        sys_clk,
  input  logic        core_reset_n,
  input  logic        enable,
  input  logic [31:0] sample_data,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_sop,
  output logic        tx_eop,
  output logic [1:0]  tx_empty,
  output logic        tx_error,
  output logic [15:0] drop_count,
  output logic [15:0] seq_num
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef MIC_FRAME_TIMESTAMP_EN
  localparam int HDR_WORDS = 5;
`else
  localparam int HDR_WORDS = 4;
`endif

  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          rdy_q, full, wr_en, pop;
  logic [2:0]    hidx;
  logic [15:0]   pcnt;
  logic [15:0]   seq_q;
  state_t        state;

`ifdef MIC_FRAME_TIMESTAMP_EN
  logic [31:0] cyc_cnt, ts_q;

  always_ff @(posedge sys_clk or negedge core_reset_n) begin
    if (!core_reset_n) cyc_cnt <= 32'd0;
    else               cyc_cnt <= cyc_cnt + 32'd1;
  end
`endif

  // full comes from the registered count, so a same-cycle pop never frees a slot early
  assign full         = (count == CW'(FIFO_DEPTH));
  assign sample_ready = rdy_q && !full;
  assign wr_en        = sample_valid && sample_ready;
  assign pop          = (state == PAY) && tx_valid && tx_ready;
  assign tx_empty     = 2'b00;
  assign tx_error     = 1'b0;
  assign seq_num      = seq_q;

  function automatic logic [31:0] hdr_word(input logic [2:0] idx);
    case (idx)
      3'd0:    hdr_word = DST_MAC[47:16];
      3'd1:    hdr_word = {DST_MAC[15:0], SRC_MAC[47:32]};
      3'd2:    hdr_word = SRC_MAC[31:0];
      3'd3:    hdr_word = {ETHERTYPE, seq_q};
`ifdef MIC_FRAME_TIMESTAMP_EN
      3'd4:    hdr_word = ts_q;
`endif
      default: hdr_word = 32'h0;
    endcase
  endfunction

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_ptr] <= sample_data;
  end

  always_ff @(posedge sys_clk or negedge core_reset_n) begin
    if (!core_reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rdy_q      <= 1'b0;
      drop_count <= 16'd0;
    end else begin
      rdy_q <= 1'b1;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_en) - CW'(pop);
      if (sample_valid && full && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end

  // Output words are registered one ahead: each transfer loads the next word,
  // so data/sop/eop hold while the MAC stalls.
  always_ff @(posedge sys_clk or negedge core_reset_n) begin
    if (!core_reset_n) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
      tx_sop   <= 1'b0;
      tx_eop   <= 1'b0;
      tx_data  <= 32'h0;
      hidx     <= 3'd0;
      pcnt     <= 16'd0;
      seq_q    <= 16'd0;
`ifdef MIC_FRAME_TIMESTAMP_EN
      ts_q     <= 32'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (enable && count >= CW'(SAMPLES_PER_FRAME)) begin
            state    <= HDR;
            tx_valid <= 1'b1;
            tx_sop   <= 1'b1;
            tx_data  <= hdr_word(3'd0);
            hidx     <= 3'd0;
`ifdef MIC_FRAME_TIMESTAMP_EN
            ts_q     <= cyc_cnt;
`endif
          end
        end
        HDR: begin
          if (tx_ready) begin
            tx_sop <= 1'b0;
            if (hidx == 3'(HDR_WORDS - 1)) begin
              state   <= PAY;
              tx_data <= mem[rd_ptr];
              pcnt    <= 16'd0;
              tx_eop  <= 1'b0;
            end else begin
              hidx    <= hidx + 3'd1;
              tx_data <= hdr_word(hidx + 3'd1);
            end
          end
        end
        PAY: begin
          if (tx_ready) begin
            if (tx_eop) begin
              state    <= IDLE;
              tx_valid <= 1'b0;
              tx_eop   <= 1'b0;
              seq_q    <= seq_q + 16'd1;
            end else begin
              tx_data <= mem[rd_ptr + AW'(1)];
              pcnt    <= pcnt + 16'd1;
              tx_eop  <= (pcnt == 16'(SAMPLES_PER_FRAME - 2));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mic_frame_packer.sv
// Directed bench for mic_frame_packer with a 16-sample frame and 256-word FIFO.
module tb_mic_frame_packer;

  localparam int SPF = 16;

  logic        sys_clk = 1'b0;
  logic        core_reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] sample_data = 32'h0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        tx_sop, tx_eop, tx_error;
  logic [1:0]  tx_empty;
  logic [15:0] drop_count, seq_num;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [31:0] cap_data [64];
  logic        cap_sop  [64];
  logic        cap_eop  [64];

  mic_frame_packer #(.SAMPLES_PER_FRAME(SPF), .FIFO_DEPTH(256)) dut (
    .sys_clk(sys_clk), .core_reset_n(core_reset_n), .enable(enable),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_empty(tx_empty), .tx_error(tx_error),
    .drop_count(drop_count), .seq_num(seq_num)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", pass_cnt, chk_cnt);
    $fatal(1);
  end

  task automatic apply_reset();
    core_reset_n = 1'b0;
    sample_valid = 1'b0;
    tx_ready     = 1'b0;
    repeat (2) @(negedge sys_clk);
    core_reset_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic push_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      sample_valid = 1'b1;
      sample_data  = base + 32'(i);
    end
    @(negedge sys_clk);
    sample_valid = 1'b0;
  endtask

  // Records transferred words; errs counts stall instability, bubbles and an unfinished frame.
  task automatic capture(input bit toggle, input int max_words, input int drop_en_at,
                         output int n, output int errs);
    int ph = 0;
    bit stalled = 0;
    bit done = 0;
    logic [31:0] pd = 32'h0;
    logic ps = 1'b0, pe = 1'b0;
    n = 0;
    errs = 0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge sys_clk);
      tx_ready = toggle ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
      ph++;
      if (n == drop_en_at) enable = 1'b0;
      if (stalled && (!tx_valid || tx_data !== pd || tx_sop !== ps || tx_eop !== pe)) errs++;
      if (n > 0 && !tx_valid) errs++;
      stalled = 0;
      if (tx_valid && tx_ready) begin
        cap_data[n] = tx_data;
        cap_sop[n]  = tx_sop;
        cap_eop[n]  = tx_eop;
        n++;
        if (tx_eop || n == max_words) done = 1;
      end else if (tx_valid) begin
        stalled = 1;
        pd = tx_data;
        ps = tx_sop;
        pe = tx_eop;
      end
    end
    if (!done) errs++;
  endtask

  task automatic test_reset();
    core_reset_n = 1'b0;
    @(negedge sys_clk);
    chk_cnt++;
    if ({tx_valid, tx_sop, tx_eop} !== 3'b000) $display("FAIL reset_ctrl: got %b expected 000", {tx_valid, tx_sop, tx_eop});
    else pass_cnt++;
    chk_cnt++;
    if (tx_data !== 32'h0) $display("FAIL reset_data: got %h expected 00000000", tx_data);
    else pass_cnt++;
    chk_cnt++;
    if (sample_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", sample_ready);
    else pass_cnt++;
    chk_cnt++;
    if ({drop_count, seq_num} !== 32'h0) $display("FAIL reset_counts: got %h expected 0", {drop_count, seq_num});
    else pass_cnt++;
    core_reset_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    chk_cnt++;
    if (sample_ready !== 1'b1) $display("FAIL ready_after_reset: got %b expected 1", sample_ready);
    else pass_cnt++;
    chk_cnt++;
    if ({tx_empty, tx_error} !== 3'b000) $display("FAIL empty_error: got %b expected 000", {tx_empty, tx_error});
    else pass_cnt++;
  endtask

  task automatic test_basic_frame();
    int n, errs, bad;
    logic [31:0] exp_w;
    enable = 1'b1;
    push_words(32'h1000, SPF);
    capture(1'b0, 99, -1, n, errs);
    chk_cnt++;
    if (n !== 20 || errs !== 0) $display("FAIL basic_len: got %0d words/%0d errs expected 20/0", n, errs);
    else pass_cnt++;
    chk_cnt++;
    if (cap_data[0] !== 32'hFFFFFFFF || cap_sop[0] !== 1'b1) $display("FAIL basic_w0: got %h sop %b expected ffffffff sop 1", cap_data[0], cap_sop[0]);
    else pass_cnt++;
    chk_cnt++;
    if (cap_data[1] !== 32'hFFFF0001 || cap_data[2] !== 32'h02030405) $display("FAIL basic_w1w2: got %h %h expected ffff0001 02030405", cap_data[1], cap_data[2]);
    else pass_cnt++;
    chk_cnt++;
    if (cap_data[3] !== 32'h88B50000) $display("FAIL basic_w3: got %h expected 88b50000", cap_data[3]);
    else pass_cnt++;
    bad = 0;
    exp_w = 32'h0;
    for (int i = 0; i < SPF; i++)
      if (cap_data[4+i] !== 32'h1000 + 32'(i) && bad++ == 0) exp_w = 32'h1000 + 32'(i);
    chk_cnt++;
    if (bad !== 0) $display("FAIL basic_payload: got %0d bad words, first expected %h", bad, exp_w);
    else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 19; i++) if (cap_eop[i] !== 1'b0 || (i > 0 && cap_sop[i] !== 1'b0)) bad++;
    chk_cnt++;
    if (cap_eop[19] !== 1'b1 || bad !== 0) $display("FAIL basic_eop: got eop19 %b stray %0d expected 1 and 0", cap_eop[19], bad);
    else pass_cnt++;
    @(negedge sys_clk);
    chk_cnt++;
    if (seq_num !== 16'd1) $display("FAIL basic_seq: got %0d expected 1", seq_num);
    else pass_cnt++;
  endtask

  task automatic test_back_pressure();
    int n, errs, bad;
    push_words(32'h1000, SPF);
    capture(1'b1, 99, -1, n, errs);
    chk_cnt++;
    if (n !== 20 || errs !== 0) $display("FAIL bp_len_stable: got %0d words/%0d errs expected 20/0", n, errs);
    else pass_cnt++;
    chk_cnt++;
    if (cap_data[0] !== 32'hFFFFFFFF || cap_data[3] !== 32'h88B50001 || cap_eop[19] !== 1'b1)
      $display("FAIL bp_header: got w0 %h w3 %h eop %b expected ffffffff 88b50001 1", cap_data[0], cap_data[3], cap_eop[19]);
    else pass_cnt++;
    bad = 0;
    for (int i = 0; i < SPF; i++) if (cap_data[4+i] !== 32'h1000 + 32'(i)) bad++;
    chk_cnt++;
    if (bad !== 0) $display("FAIL bp_payload: got %0d bad words expected 0", bad);
    else pass_cnt++;
    @(negedge sys_clk);
  endtask

  task automatic test_overflow();
    int acc, n, errs, bad;
    apply_reset();
    enable = 1'b1;
    acc = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk);
      if (sample_ready) acc++;
      sample_valid = 1'b1;
      sample_data  = 32'h2000 + 32'(i);
    end
    @(negedge sys_clk);
    sample_valid = 1'b0;
    chk_cnt++;
    if (acc !== 256) $display("FAIL ovf_accepted: got %0d expected 256", acc);
    else pass_cnt++;
    chk_cnt++;
    if (sample_ready !== 1'b0) $display("FAIL ovf_ready: got %b expected 0", sample_ready);
    else pass_cnt++;
    chk_cnt++;
    if (drop_count !== 16'd44) $display("FAIL ovf_drops: got %0d expected 44", drop_count);
    else pass_cnt++;
    capture(1'b0, 99, -1, n, errs);
    bad = 0;
    for (int i = 0; i < SPF; i++) if (cap_data[4+i] !== 32'h2000 + 32'(i)) bad++;
    chk_cnt++;
    if (n !== 20 || errs !== 0 || bad !== 0) $display("FAIL ovf_frame: got %0d words %0d errs %0d bad expected 20 0 0", n, errs, bad);
    else pass_cnt++;
  endtask

  task automatic test_seq_wrap();
    int n, errs;
    apply_reset();
    enable = 1'b1;
    @(negedge sys_clk);
    force dut.seq_q = 16'hFFFF;
    @(negedge sys_clk);
    release dut.seq_q;
    push_words(32'h3000, SPF);
    capture(1'b0, 99, -1, n, errs);
    chk_cnt++;
    if (cap_data[3] !== 32'h88B5FFFF) $display("FAIL wrap_w3_ffff: got %h expected 88b5ffff", cap_data[3]);
    else pass_cnt++;
    @(negedge sys_clk);
    chk_cnt++;
    if (seq_num !== 16'h0000) $display("FAIL wrap_seq: got %h expected 0000", seq_num);
    else pass_cnt++;
    push_words(32'h3010, SPF);
    capture(1'b0, 99, -1, n, errs);
    chk_cnt++;
    if (cap_data[3] !== 32'h88B50000 || cap_data[4] !== 32'h3010) $display("FAIL wrap_next: got w3 %h w4 %h expected 88b50000 00003010", cap_data[3], cap_data[4]);
    else pass_cnt++;
    @(negedge sys_clk);
  endtask

  task automatic test_enable();
    int n, errs, viol, bad;
    apply_reset();
    enable = 1'b0;
    push_words(32'h4000, 64);
    viol = 0;
    repeat (20) begin
      @(negedge sys_clk);
      if (tx_valid !== 1'b0) viol++;
    end
    chk_cnt++;
    if (viol !== 0) $display("FAIL en_idle: got %0d valid cycles expected 0", viol);
    else pass_cnt++;
    enable = 1'b1;
    @(negedge sys_clk);
    chk_cnt++;
    if (tx_valid !== 1'b1 || tx_sop !== 1'b1 || tx_data !== 32'hFFFFFFFF) $display("FAIL en_start: got v %b sop %b %h expected 1 1 ffffffff", tx_valid, tx_sop, tx_data);
    else pass_cnt++;
    capture(1'b0, 99, 6, n, errs);
    bad = 0;
    for (int i = 0; i < SPF; i++) if (cap_data[4+i] !== 32'h4000 + 32'(i)) bad++;
    chk_cnt++;
    if (n !== 20 || errs !== 0 || bad !== 0 || cap_eop[19] !== 1'b1) $display("FAIL en_complete: got %0d words %0d errs %0d bad expected 20 0 0", n, errs, bad);
    else pass_cnt++;
    viol = 0;
    repeat (20) begin
      @(negedge sys_clk);
      if (tx_valid !== 1'b0) viol++;
    end
    chk_cnt++;
    if (viol !== 0) $display("FAIL en_no_restart: got %0d valid cycles expected 0", viol);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    int n, errs, viol, bad;
    enable = 1'b1;
    capture(1'b0, 8, -1, n, errs);
    chk_cnt++;
    if (n !== 8 || cap_data[4] !== 32'h4010) $display("FAIL rst_pre: got %0d words w4 %h expected 8 00004010", n, cap_data[4]);
    else pass_cnt++;
    @(negedge sys_clk);
    core_reset_n = 1'b0;
    #1;
    chk_cnt++;
    if (tx_valid !== 1'b0 || tx_eop !== 1'b0) $display("FAIL rst_truncate: got v %b eop %b expected 0 0", tx_valid, tx_eop);
    else pass_cnt++;
    chk_cnt++;
    if (seq_num !== 16'd0 || sample_ready !== 1'b0) $display("FAIL rst_state: got seq %0d ready %b expected 0 0", seq_num, sample_ready);
    else pass_cnt++;
    @(negedge sys_clk);
    core_reset_n = 1'b1;
    tx_ready = 1'b0;
    viol = 0;
    repeat (5) begin
      @(negedge sys_clk);
      if (tx_valid !== 1'b0) viol++;
    end
    chk_cnt++;
    if (viol !== 0) $display("FAIL rst_fifo_empty: got %0d valid cycles expected 0", viol);
    else pass_cnt++;
    push_words(32'h5000, SPF);
    capture(1'b0, 99, -1, n, errs);
    bad = 0;
    for (int i = 0; i < SPF; i++) if (cap_data[4+i] !== 32'h5000 + 32'(i)) bad++;
    chk_cnt++;
    if (n !== 20 || errs !== 0 || cap_sop[0] !== 1'b1 || cap_data[3] !== 32'h88B50000 || bad !== 0)
      $display("FAIL rst_next_frame: got %0d words sop %b w3 %h %0d bad expected 20 1 88b50000 0", n, cap_sop[0], cap_data[3], bad);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_back_pressure();
    test_overflow();
    test_seq_wrap();
    test_enable();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mic_frame_packer.md
Name: mic_frame_packer

Overview:
- Upstream feeder for the TSE MAC transmit path. Collects 32-bit microphone-array sample words from the capture logic into an internal FIFO.
- Once a full frame's worth of samples is buffered, emits one raw Ethernet frame on an Avalon-ST source into the MAC's transmit FIFO interface.
- Frame layout: fixed L2 header, 16-bit sequence number, then samples. The MAC appends the FCS and padding.

Parameters:
- SAMPLES_PER_FRAME, 64: payload words per frame; legal range 11..366 (keeps frame 60..1480 bytes).
- FIFO_DEPTH, 256: sample FIFO depth in words; power of two, at least SAMPLES_PER_FRAME.
- DST_MAC, 48'hFFFF_FFFF_FFFF: destination MAC.
- SRC_MAC, 48'h0001_0203_0405: source MAC.
- ETHERTYPE, 16'h88B5: EtherType field.

Ports:
- sys_clk  in  1  single clock for all logic, sample side and MAC tx side.
- core_reset_n  in  1  asynchronous active-low reset.
- enable  in  1  permits new frames to start.
- sample_data  in  32  sample word.
- sample_valid  in  1  sample_data valid.
- sample_ready  out  1  FIFO can accept a word.
- tx_data  out  32  Avalon-ST data; first byte on wire is in bits 31:24.
- tx_valid  out  1  Avalon-ST valid.
- tx_ready  in  1  Avalon-ST ready; readyLatency 0.
- tx_sop  out  1  start of packet.
- tx_eop  out  1  end of packet.
- tx_empty  out  2  empty bytes in the eop word; always 0.
- tx_error  out  1  always 0.
- drop_count  out  16  samples dropped on overflow; saturates at 16'hFFFF.
- seq_num  out  16  sequence number of the next frame to be sent.

Behaviour:
- Reset (async, core_reset_n = 0):
  - FIFO emptied; state goes to IDLE.
  - tx_valid, tx_sop, tx_eop = 0; tx_data = 0.
  - sample_ready = 0 while in reset, 1 after release.
  - drop_count = 0; seq_num = 0.
  - Reset asserted mid-frame truncates the frame immediately; no eop is issued.
- Sample side:
  - sample_ready = !full, where full is computed from the registered FIFO count.
  - A write occurs when sample_valid && sample_ready.
  - When full, a word with sample_valid = 1 is dropped and drop_count increments (saturating).
  - A FIFO read in the same cycle does not un-block a write in that cycle.
- Transfer rule: a word transfers when tx_valid && tx_ready.
  - While tx_valid = 1 && tx_ready = 0, tx_data, tx_sop and tx_eop hold stable.
  - tx_valid never drops mid-frame; no bubbles between header and payload words.
- FSM: IDLE -> HDR -> PAY -> IDLE.
  - IDLE: go to HDR when enable = 1 and FIFO count >= SAMPLES_PER_FRAME. tx_valid with tx_sop is asserted on the following cycle.
  - HDR: sends 4 words; advances on each transfer. After the last header word transfers, go to PAY.
    - W0 = DST_MAC[47:16]
    - W1 = {DST_MAC[15:0], SRC_MAC[47:32]}
    - W2 = SRC_MAC[31:0]
    - W3 = {ETHERTYPE, seq_num}
  - PAY: sends SAMPLES_PER_FRAME FIFO words in write order; exactly one FIFO pop per payload transfer. tx_eop = 1 on the last payload word. When it transfers, seq_num increments (wrap 16'hFFFF -> 0) and the FSM returns to IDLE.
- enable deasserted mid-frame: the current frame completes; no new frame starts.
- Back-to-back frames: IDLE is held for at least 1 cycle between frames.
- Frame length: 16 + 4*SAMPLES_PER_FRAME bytes, excluding FCS.

Optional Feature:
- Macro: MIC_FRAME_TIMESTAMP_EN.
- Defined:
  - A free-running 32-bit cycle counter (reset 0, wraps) is latched on the IDLE->HDR transition.
  - It is sent as an extra header word W4 after W3, so the header is 5 words.
  - Frame length grows by 4 bytes.
- Undefined: no counter is present; the header is 4 words.

Test Plan:
- Reset, enable = 1, SAMPLES_PER_FRAME = 16, tx_ready = 1, write samples 0x1000..0x100F -> one frame of 20 words:
  - sop on W0 = 0xFFFFFFFF; W3 = 0x88B50000.
  - Payload 0x1000..0x100F; eop on word 20.
  - seq_num = 1 afterwards.
- Same stimulus, tx_ready toggling with pattern 1,0,0,1 repeated -> identical word sequence; data, sop and eop stable while stalled.
- tx_ready = 0, push 300 samples into FIFO_DEPTH = 256 -> sample_ready = 0 after 256 writes; drop_count = 44.
- Force seq_num to 16'hFFFF via 65535 frames, or preload in simulation -> W3 = 0x88B5FFFF, next frame W3 = 0x88B50000.
- enable = 0 with 64 samples buffered -> no tx_valid. Assert enable -> frame starts with tx_sop 1 cycle later. Deassert enable mid-payload -> frame completes with eop.
- core_reset_n pulsed low mid-payload -> tx_valid = 0 immediately; FIFO empty; seq_num = 0; next frame begins cleanly with sop.
